pipe_skid_stage: RTL and testbench

Two-entry registered pipeline stage (main + skid register) with valid/ready handshake on both sides. Sits between adjacent OOO pipeline stages (e.g. decode -> rename), directly downstream of the flip-flop-level state registers and replacing bare D_FF stage latches where back-pressure is needed. Provides full throughput, registered in_ready (no combinational ready path), and a synchronous flush for branch-mispredict recovery.

---
 rtl/pipe_skid_stage_pkg.sv | 25 ++
 rtl/pipe_skid_stage_en_reg.sv | 32 +++
 rtl/pipe_skid_stage.sv | 113 +++++++++++
 tb/tb_pipe_skid_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared types for the two-entry skid pipeline stage.
// The state encoding doubles as the occupancy count.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    function automatic logic [OCC_W-1:0] occ_of(input skid_state_e s);
        logic [OCC_W-1:0] occ;
        occ = '0;
        case (s)
            EMPTY:   occ = 2'd0;
            BUSY:    occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_en_reg.sv
// WIDTH-bit register with load enable and asynchronous active-low clear.
module en_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry registered pipeline stage (main + skid) with registered in_ready
// and a synchronous flush that drops every held entry.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    // Handshake: a transfer happens on a posedge where valid and ready are
    // both 1; valid and payload hold until that edge, and ready never looks
    // at the same-cycle valid. in_ready and out_valid decode state_q only.

    skid_state_e state_q;
    skid_state_e state_d;

    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             skid_en;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_en = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d        = BUSY;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Data left in the registers after a flush is masked by out_valid=0.
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    en_reg #(.WIDTH(WIDTH)) u_main_reg (
        .clk   (clk),
        .rst_n (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    en_reg #(.WIDTH(WIDTH)) u_skid_reg (
        .clk   (clk),
        .rst_n (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and random-handshake bench for pipe_skid_stage (WIDTH=8).
module tb_pipe_skid_stage;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int tests;
    int failed;

    logic [W-1:0] exp_q[$];

    pipe_skid_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic v, input logic rdy,
                               input logic [1:0] occ, input logic [W-1:0] d, input logic chk_d);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_in_ready"},  32'(in_ready),  32'(rdy));
        check({tag, "_occ"},       32'(occupancy), 32'(occ));
        if (chk_d) check({tag, "_out_data"}, 32'(out_data), 32'(d));
    endtask

    initial begin
        logic         r_v;
        logic         r_r;
        logic         r_f;
        logic [W-1:0] r_d;
        logic         exp_rdy;
        logic         rdy_a;
        logic         mdl_in_fire;
        logic         mdl_out_fire;

        tests  = 0;
        failed = 0;
        reset  = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        check_state("reset", 1'b0, 1'b1, 2'd0, 8'h00, 1'b1);
        step();
        step();
        reset = 1'b1;
        step();
        check_state("idle", 1'b0, 1'b1, 2'd0, 8'h00, 1'b1);

        // streaming 1..8 with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            step();
            check_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, W'(i), 1'b1);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check_state("stream_drain", 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);

        // back-pressure: A, B accepted, C held upstream
        drive(1'b1, 8'h0A, 1'b0, 1'b0);
        step();
        check_state("bp_a", 1'b1, 1'b1, 2'd1, 8'h0A, 1'b1);
        drive(1'b1, 8'h0B, 1'b0, 1'b0);
        step();
        check_state("bp_b", 1'b1, 1'b0, 2'd2, 8'h0A, 1'b1);
        drive(1'b1, 8'h0C, 1'b0, 1'b0);
        step();
        check_state("bp_hold", 1'b1, 1'b0, 2'd2, 8'h0A, 1'b1);
        drive(1'b1, 8'h0C, 1'b1, 1'b0);
        step();
        check_state("bp_out_b", 1'b1, 1'b1, 2'd1, 8'h0B, 1'b1);
        step();
        check_state("bp_out_c", 1'b1, 1'b1, 2'd1, 8'h0C, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check_state("bp_drain", 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);

        // simultaneous in/out while BUSY
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        step();
        check_state("sim_load", 1'b1, 1'b1, 2'd1, 8'h11, 1'b1);
        drive(1'b1, 8'h22, 1'b1, 1'b0);
        step();
        check_state("sim_pass", 1'b1, 1'b1, 2'd1, 8'h22, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check_state("sim_drain", 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);

        // flush while FULL with in_valid high
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h44, 1'b0, 1'b0);
        step();
        check_state("fl_full", 1'b1, 1'b0, 2'd2, 8'h33, 1'b1);
        drive(1'b1, 8'h99, 1'b0, 1'b1);
        step();
        check_state("fl_kill", 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        step();
        check_state("fl_after", 1'b1, 1'b1, 2'd1, 8'h55, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        check_state("fl_drain", 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);

        // flush in BUSY discards the input accepted that same edge
        drive(1'b1, 8'h66, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        step();
        check_state("fl_busy", 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        check_state("fl_busy_idle", 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);

        // asynchronous reset mid-stream while FULL
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'h34, 1'b0, 1'b0);
        step();
        check_state("rst_full", 1'b1, 1'b0, 2'd2, 8'h12, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check_state("rst_async", 1'b0, 1'b1, 2'd0, 8'h00, 1'b1);
        step();
        step();
        check_state("rst_hold", 1'b0, 1'b1, 2'd0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check_state("rst_release", 1'b0, 1'b1, 2'd0, 8'h00, 1'b1);

        // random valid/ready/flush against the expected queue
        exp_q.delete();
        for (int c = 0; c < 10000; c++) begin
            exp_rdy = (exp_q.size() < 2);
            check("rnd_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            check("rnd_occ", 32'(occupancy), 32'(exp_q.size()));
            if (exp_q.size() > 0) check("rnd_out_data", 32'(out_data), 32'(exp_q[0]));

            r_v = 1'($urandom_range(0, 1));
            r_r = 1'($urandom_range(0, 1));
            r_f = ($urandom_range(0, 31) == 0);
            r_d = W'($urandom_range(0, 255));
            drive(r_v, r_d, ~r_r, r_f);
            #1;
            rdy_a = in_ready;
            out_ready = r_r;
            #1;
            check("rnd_ready_indep", 32'(in_ready), 32'(rdy_a));

            mdl_in_fire  = r_v & exp_rdy;
            mdl_out_fire = r_r & (exp_q.size() > 0);
            @(posedge clk);
            #1;
            if (r_f) begin
                exp_q.delete();
            end else begin
                if (mdl_out_fire) void'(exp_q.pop_front());
                if (mdl_in_fire) exp_q.push_back(r_d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
